// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the memory-port arbiter and the caches.
//   state_t     : arbiter FSM states
//   CLI_I/CLI_D : client ids, used as the round-robin pointer value
//   ADDR_W/DATA_W/DEF_TIMEOUT : default block address/data widths and watchdog limit
package arb_pkg;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int DEF_TIMEOUT = 1023;
  localparam logic CLI_I = 1'b0;
  localparam logic CLI_D = 1'b1;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating cycle counter with a sticky timeout flag.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (granted and waiting); low clears the counter
//   err        : sticky, set once TIMEOUT consecutive enabled cycles have elapsed
//   TIMEOUT=0 disables the flag.
module arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic err
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= !en ? '0 : (cnt == W'(TIMEOUT) ? cnt : cnt + 1'b1);
      // the enabled cycle that brings the count to TIMEOUT raises the flag
      if (TIMEOUT != 0 && en && cnt == W'(TIMEOUT - 1)) err <= 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache and D-cache miss paths.
//   ic_*  : I-cache block read request / ready pulse / read data
//   dc_*  : D-cache refill or writeback request / ready pulse / read data
//   mem_* : registered memory strobes, address and write data; mem_ready_i/mem_rdata_i back
//   busy_o        : a grant is in progress
//   err_timeout_o : sticky, memory did not answer within TIMEOUT grant cycles
//   err_proto_o   : sticky, D-cache raised read and write together
// Round-robin between clients, except that a D writeback keeps the port for the D refill after it.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = arb_pkg::ADDR_W,
  parameter int DATA_W = arb_pkg::DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_read_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ready_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  input  logic              dc_read_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_timeout_o,
  output logic              err_proto_o
);
  state_t state, state_n;
  logic rr_ptr, d_lock, d_req, pick_d, d_wr;
  assign d_req = dc_read_i | dc_write_i;
  // a pending writeback lock beats the round-robin pointer
  assign pick_d = d_req && (!ic_read_i || d_lock || rr_ptr == CLI_D);
  assign d_wr = pick_d && dc_write_i;
  assign busy_o = state != IDLE;
  assign ic_ready_o = state == GRANT_I && mem_ready_i;
  assign dc_ready_o = state == GRANT_D && mem_ready_i;
  assign ic_rdata_o = mem_rdata_i;
  assign dc_rdata_o = mem_rdata_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = pick_d ? GRANT_D : (ic_read_i ? GRANT_I : IDLE);
    else if (mem_ready_i) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= CLI_D;
      d_lock <= 1'b0;
      err_proto_o <= 1'b0;
      mem_read_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (dc_read_i && dc_write_i) err_proto_o <= 1'b1;
      if (state == IDLE) begin
        if (!d_req) d_lock <= 1'b0;
        if (pick_d || ic_read_i) begin
          mem_addr_o <= pick_d ? dc_addr_i : ic_addr_i;
          mem_wdata_o <= pick_d ? dc_wdata_i : '0;
          mem_write_o <= d_wr;
          mem_read_o <= !d_wr;
        end
      end else if (mem_ready_i) begin
        mem_read_o <= 1'b0;
        mem_write_o <= 1'b0;
        if (state == GRANT_I) rr_ptr <= CLI_D;
        else if (mem_write_o) d_lock <= 1'b1;
        else begin
          rr_ptr <= CLI_I;
          d_lock <= 1'b0;
        end
      end
    end
  end
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .en(busy_o),
    .err(err_timeout_o)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ic_read_i = 1'b0, dc_read_i = 1'b0, dc_write_i = 1'b0, mem_ready_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0, dc_addr_i = '0;
  logic [DW-1:0] dc_wdata_i = '0, mem_rdata_i = '0;
  logic ic_ready_o, dc_ready_o, mem_read_o, mem_write_o, busy_o, err_timeout_o, err_proto_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] ic_rdata_o, dc_rdata_o, mem_wdata_o;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_read_i(ic_read_i), .ic_addr_i(ic_addr_i), .ic_ready_o(ic_ready_o), .ic_rdata_o(ic_rdata_o),
    .dc_read_i(dc_read_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_ready_o(dc_ready_o), .dc_rdata_o(dc_rdata_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .err_proto_o(err_proto_o)
  );
  typedef struct packed {
    logic wr;
    logic prot;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;
  op_t iq[$], dq[$];
  op_t m_op;
  int n_cmp = 0, n_err = 0, cyc = 0, mcnt = 0, lat = 3, gcnt = 0;
  int strobe_cyc = 0, ic_rdy_cyc = 0, n_icr = 0, n_dcr = 0, t0 = 0;
  bit fixed_lat = 0, mem_on = 1, noise = 0, pop_i = 0, pop_d = 0, prev_strobe = 0;
  bit m_busy = 0, n_busy = 0, m_d = 0, pref_d = 1, lock = 0, exp_to = 0, exp_proto = 0;
  int comp_log[$];
  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic op_t mk(logic wr, logic prot, logic [AW-1:0] a, logic [DW-1:0] d);
    op_t o;
    o.wr = wr;
    o.prot = prot;
    o.addr = a;
    o.data = d;
    return o;
  endfunction
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_log(string tag, int exp[$]);
    chk({tag, "_count"}, comp_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < comp_log.size(); k++) chk(tag, comp_log[k], exp[k]);
  endtask
  task automatic tick();
    bit strobe, ir, dr;
    @(posedge clk);
    #1;
    cyc++;
    m_busy = n_busy;
    if (pop_i) void'(iq.pop_front());
    if (pop_d) void'(dq.pop_front());
    pop_i = 0;
    pop_d = 0;
    ic_read_i = iq.size() > 0;
    ic_addr_i = iq.size() > 0 ? iq[0].addr : AW'($urandom);
    dc_write_i = dq.size() > 0 && dq[0].wr;
    dc_read_i = dq.size() > 0 && (!dq[0].wr || dq[0].prot);
    dc_addr_i = dq.size() > 0 ? dq[0].addr : AW'($urandom);
    dc_wdata_i = dq.size() > 0 ? dq[0].data : rnd_data();
    strobe = mem_read_o | mem_write_o;
    if (strobe && !prev_strobe) begin
      strobe_cyc = cyc;
      if (!fixed_lat) lat = 1 + $urandom_range(0, 3);
    end
    mcnt = strobe ? mcnt + 1 : 0;
    prev_strobe = strobe;
    mem_ready_i = strobe ? (mem_on && mcnt >= lat) : (noise && $urandom_range(0, 3) == 0);
    mem_rdata_i = rnd_data();
    #1;
    chk("busy", busy_o, m_busy);
    chk("mem_read", mem_read_o, m_busy && !m_op.wr);
    chk("mem_write", mem_write_o, m_busy && m_op.wr);
    if (m_busy) chk("mem_addr", mem_addr_o, m_op.addr);
    if (m_busy && m_op.wr) chk("mem_wdata", mem_wdata_o, m_op.data);
    chk("ic_ready", ic_ready_o, m_busy && !m_d && mem_ready_i);
    chk("dc_ready", dc_ready_o, m_busy && m_d && mem_ready_i);
    if (ic_ready_o) chk("ic_rdata", ic_rdata_o, mem_rdata_i);
    if (dc_ready_o) chk("dc_rdata", dc_rdata_o, mem_rdata_i);
    chk("err_timeout", err_timeout_o, exp_to);
    chk("err_proto", err_proto_o, exp_proto);
    if (ic_ready_o) begin
      ic_rdy_cyc = cyc;
      n_icr++;
      comp_log.push_back(0);
    end
    if (dc_ready_o) begin
      n_dcr++;
      comp_log.push_back(mem_write_o ? 2 : 1);
    end
    if (dc_read_i && dc_write_i) exp_proto = 1;
    if (m_busy) begin
      gcnt++;
      if (gcnt >= TO) exp_to = 1;
      n_busy = !mem_ready_i;
      if (mem_ready_i && !m_d) begin
        pop_i = 1;
        pref_d = 1;
      end else if (mem_ready_i) begin
        pop_d = 1;
        if (m_op.wr) lock = 1;
        else begin
          pref_d = 0;
          lock = 0;
        end
      end
    end else begin
      gcnt = 0;
      ir = ic_read_i;
      dr = dc_read_i | dc_write_i;
      m_d = dr && (!ir || lock || pref_d);
      if (!dr) lock = 0;
      n_busy = ir || dr;
      m_op = m_d ? mk(dc_write_i, 1'b0, dc_addr_i, dc_wdata_i) : mk(1'b0, 1'b0, ic_addr_i, '0);
    end
  endtask
  task automatic drain(int maxc);
    int k = 0;
    while ((iq.size() > 0 || dq.size() > 0 || m_busy || n_busy) && k < maxc) begin
      tick();
      k++;
    end
    chk("drain_bound", k < maxc, 1);
  endtask
  task automatic do_reset();
    rst_n = 0;
    {ic_read_i, dc_read_i, dc_write_i, mem_ready_i} = '0;
    iq.delete();
    dq.delete();
    comp_log.delete();
    {m_busy, n_busy, pop_i, pop_d, lock, exp_to, exp_proto, prev_strobe} = '0;
    pref_d = 1;
    gcnt = 0;
    mcnt = 0;
    n_icr = 0;
    n_dcr = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask
  initial begin
    #12;
    chk("rst_mem_read", mem_read_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err_to", err_timeout_o, 0);
    chk("rst_err_proto", err_proto_o, 0);
    do_reset();
    fixed_lat = 1;
    lat = 3;
    t0 = cyc + 1;
    iq.push_back(mk(1'b0, 1'b0, 28'h0000040, '0));
    drain(50);
    chk("t1_strobe_cyc", strobe_cyc - t0, 1);
    chk("t1_ready_cyc", ic_rdy_cyc - t0, 3);
    chk("t1_ic_pulses", n_icr, 1);
    chk("t1_dc_pulses", n_dcr, 0);
    fixed_lat = 0;
    do_reset();
    iq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
    dq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
    drain(100);
    chk_log("t2_order", '{1, 0});
    chk("t2_ic_pulses", n_icr, 1);
    chk("t2_dc_pulses", n_dcr, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      iq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
      dq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
    end
    drain(200);
    chk_log("t3_order", '{1, 0, 1, 0, 1, 0});
    do_reset();
    dq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
    drain(50);
    comp_log.delete();
    dq.push_back(mk(1'b1, 1'b0, 28'h0ABCDE0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF));
    dq.push_back(mk(1'b0, 1'b0, 28'h0123450, '0));
    tick();
    iq.push_back(mk(1'b0, 1'b0, 28'h0000080, '0));
    drain(100);
    chk_log("t4_order", '{2, 1, 0});
    do_reset();
    noise = 1;
    for (int k = 0; k < 400; k++) begin
      if (iq.size() < 2 && $urandom_range(0, 3) == 0) iq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
      if (dq.size() == 0 && $urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) dq.push_back(mk(1'b1, 1'b0, AW'($urandom), rnd_data()));
        dq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
      end
      tick();
    end
    noise = 0;
    drain(200);
    chk("rnd_progress", comp_log.size() > 20, 1);
    do_reset();
    mem_on = 0;
    iq.push_back(mk(1'b0, 1'b0, AW'($urandom), '0));
    repeat (12) tick();
    chk("wd_flag", err_timeout_o, 1);
    chk("wd_no_pulse_yet", n_icr, 0);
    mem_on = 1;
    drain(20);
    chk("wd_late_done", n_icr, 1);
    chk("wd_sticky", err_timeout_o, 1);
    do_reset();
    mem_on = 0;
    dq.push_back(mk(1'b0, 1'b0, 28'h0FEDCB0, '0));
    repeat (3) tick();
    chk("rm_busy_before", busy_o, 1);
    #1 rst_n = 0;
    #1;
    chk("rm_mem_read", mem_read_o, 0);
    chk("rm_mem_addr", mem_addr_o, 0);
    chk("rm_busy", busy_o, 0);
    mem_ready_i = 1;
    #1;
    chk("rm_dc_ready", dc_ready_o, 0);
    chk("rm_dc_pulses", n_dcr, 0);
    mem_on = 1;
    do_reset();
    dq.push_back(mk(1'b1, 1'b1, 28'h0000100, rnd_data()));
    dq.push_back(mk(1'b0, 1'b0, 28'h0000200, '0));
    drain(100);
    chk_log("t6_order", '{2, 1});
    chk("t6_err_proto", err_proto_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
